// File: rtl/bsg_manycore_crossbar.sv
// Manycore crossbar: independent fwd and rev N-by-N networks. Each network has per-port
// input FIFOs, a destination decode on the head, and a round-robin arbiter per output.
module bsg_manycore_crossbar_net #(
    parameter int num_in_x_p     = 17,
    parameter int num_in_y_p     = 8,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int width_p        = 32,
    parameter logic [num_in_x_p*num_in_y_p-1:0][31:0] fifo_els_p = {(num_in_x_p*num_in_y_p){32'd32}},
    parameter logic [num_in_x_p*num_in_y_p-1:0] use_credits_p = '0,
    parameter bit bad_dest_error_p = 1'b1,
    localparam int num_ports_lp = num_in_x_p * num_in_y_p,
    localparam int idx_w_lp = (num_ports_lp > 1) ? $clog2(num_ports_lp) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [num_ports_lp-1:0]               in_v,
    input  logic [num_ports_lp-1:0][width_p-1:0]  in_data,
    output logic [num_ports_lp-1:0]               in_ready,
    output logic [num_ports_lp-1:0]               out_v,
    output logic [num_ports_lp-1:0][width_p-1:0]  out_data,
    input  logic [num_ports_lp-1:0]               out_ready
);

    logic [num_ports_lp-1:0][width_p-1:0]  head;
    logic [num_ports_lp-1:0]               head_v;
    logic [num_ports_lp-1:0]               head_bad;
    logic [num_ports_lp-1:0][idx_w_lp-1:0] head_dest;
    logic [num_ports_lp-1:0]               deq;
    logic [num_ports_lp-1:0][num_ports_lp-1:0] req;
    logic [num_ports_lp-1:0][idx_w_lp-1:0] grant_idx;
    logic [num_ports_lp-1:0]               consumed;

    genvar gi;

    for (gi = 0; gi < num_ports_lp; gi++) begin : g_in
        localparam int els_lp   = int'(fifo_els_p[gi]);
        localparam int ptr_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;

        logic [width_p-1:0]    mem [els_lp];
        logic [ptr_w_lp-1:0]   rd_ptr_reg, wr_ptr_reg;
        logic [ptr_w_lp:0]     count_reg;
        logic                  credit_reg;
        logic                  full, enq;
        logic [x_cord_width_p-1:0] x_cord;
        logic [y_cord_width_p-1:0] y_cord;

        assign full      = (count_reg == (ptr_w_lp+1)'(els_lp));
        assign enq       = in_v[gi] & ~full;
        assign head[gi]  = mem[rd_ptr_reg];
        assign head_v[gi] = (count_reg != '0);
        assign x_cord    = head[gi][x_cord_width_p-1:0];
        assign y_cord    = head[gi][x_cord_width_p +: y_cord_width_p];
        assign head_bad[gi]  = head_v[gi] & ((int'(x_cord) >= num_in_x_p) | (int'(y_cord) >= num_in_y_p));
        assign head_dest[gi] = idx_w_lp'(int'(y_cord) * num_in_x_p + int'(x_cord));

        // Ready comes from registered state only, so a full FIFO never accepts even while draining.
        assign in_ready[gi] = use_credits_p[gi] ? credit_reg : ~full;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
                credit_reg <= 1'b0;
            end else begin
                if (enq)
                    wr_ptr_reg <= (wr_ptr_reg == ptr_w_lp'(els_lp-1)) ? '0 : wr_ptr_reg + ptr_w_lp'(1);
                if (deq[gi])
                    rd_ptr_reg <= (rd_ptr_reg == ptr_w_lp'(els_lp-1)) ? '0 : rd_ptr_reg + ptr_w_lp'(1);
                case ({enq, deq[gi]})
                    2'b10:   count_reg <= count_reg + (ptr_w_lp+1)'(1);
                    2'b01:   count_reg <= count_reg - (ptr_w_lp+1)'(1);
                    default: count_reg <= count_reg;
                endcase
                credit_reg <= deq[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (enq)
                mem[wr_ptr_reg] <= in_data[gi];
        end

        if (use_credits_p[gi]) begin : g_credit_chk
            always_ff @(posedge clk) begin
                assert (!(in_v[gi] && full))
                    else $error("crossbar: credit overflow on input port %0d", gi);
            end
        end

        if (bad_dest_error_p) begin : g_bad_dest_chk
            always_ff @(posedge clk) begin
                if (head_bad[gi])
                    $error("crossbar: port %0d dropped packet to x=%0d y=%0d", gi, x_cord, y_cord);
            end
        end
    end

    always_comb begin
        for (int d = 0; d < num_ports_lp; d++)
            for (int s = 0; s < num_ports_lp; s++)
                req[d][s] = head_v[s] & ~head_bad[s] & (head_dest[s] == idx_w_lp'(d));
    end

    for (gi = 0; gi < num_ports_lp; gi++) begin : g_out
        logic [idx_w_lp-1:0] ptr_reg, held_reg, rr_idx;
        logic                held_v_reg, rr_found;
        int                  cand;

        always_comb begin
            rr_found = 1'b0;
            rr_idx   = ptr_reg;
            cand     = 0;
            for (int i = 0; i < num_ports_lp; i++) begin
                cand = (int'(ptr_reg) + i) % num_ports_lp;
                if (!rr_found && req[gi][cand]) begin
                    rr_found = 1'b1;
                    rr_idx   = idx_w_lp'(cand);
                end
            end
        end

        // A stalled grant is pinned so the presented packet cannot change under backpressure.
        assign grant_idx[gi] = held_v_reg ? held_reg : rr_idx;
        assign out_v[gi]     = held_v_reg | rr_found;
        assign out_data[gi]  = head[grant_idx[gi]];
        assign consumed[gi]  = out_v[gi] & out_ready[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_reg    <= '0;
                held_reg   <= '0;
                held_v_reg <= 1'b0;
            end else begin
                held_v_reg <= out_v[gi] & ~out_ready[gi];
                held_reg   <= grant_idx[gi];
                if (consumed[gi])
                    ptr_reg <= (grant_idx[gi] == idx_w_lp'(num_ports_lp-1)) ? '0
                             : grant_idx[gi] + idx_w_lp'(1);
            end
        end
    end

    always_comb begin
        deq = head_bad;
        for (int s = 0; s < num_ports_lp; s++)
            for (int d = 0; d < num_ports_lp; d++)
                if (consumed[d] && (grant_idx[d] == idx_w_lp'(s)))
                    deq[s] = 1'b1;
    end

endmodule

module bsg_manycore_crossbar #(
    parameter int num_in_x_p     = 17,
    parameter int num_in_y_p     = 8,
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter logic [num_in_x_p*num_in_y_p-1:0][31:0] fwd_fifo_els_p = {(num_in_x_p*num_in_y_p){32'd32}},
    parameter logic [num_in_x_p*num_in_y_p-1:0][31:0] rev_fifo_els_p = {(num_in_x_p*num_in_y_p){32'd32}},
    parameter logic [num_in_x_p*num_in_y_p-1:0] fwd_use_credits_p = '0,
    parameter logic [num_in_x_p*num_in_y_p-1:0] rev_use_credits_p = '0,
    parameter bit bad_dest_error_p = 1'b1,
    localparam int num_ports_lp = num_in_x_p * num_in_y_p,
    // fwd: addr, data, op(2), mask(4), reg_id(5), src y/x, dst y/x (dst x at LSB)
    localparam int fwd_packet_width_lp = addr_width_p + data_width_p + 11 + 2*(x_cord_width_p + y_cord_width_p),
    // rev: type(2), data, reg_id(5), dst y/x (dst x at LSB)
    localparam int rev_packet_width_lp = data_width_p + 7 + x_cord_width_p + y_cord_width_p,
    localparam int rev_ch_width_lp = rev_packet_width_lp + 2,
    localparam int fwd_ch_width_lp = fwd_packet_width_lp + 2,
    localparam int link_sif_width_lp = fwd_ch_width_lp + rev_ch_width_lp
) (
    input  logic                                                        clk_i,
    input  logic                                                        reset_i,
    input  logic [num_in_y_p-1:0][num_in_x_p-1:0][link_sif_width_lp-1:0] links_sif_i,
    output logic [num_in_y_p-1:0][num_in_x_p-1:0][link_sif_width_lp-1:0] links_sif_o
);

    logic [num_ports_lp-1:0]                          fwd_in_v, fwd_in_ready, fwd_out_v, fwd_out_ready;
    logic [num_ports_lp-1:0][fwd_packet_width_lp-1:0] fwd_in_data, fwd_out_data;
    logic [num_ports_lp-1:0]                          rev_in_v, rev_in_ready, rev_out_v, rev_out_ready;
    logic [num_ports_lp-1:0][rev_packet_width_lp-1:0] rev_in_data, rev_out_data;

    genvar gi;

    // Link layout per port, MSB first: {fwd {v, packet, ready}, rev {v, packet, ready}}.
    for (gi = 0; gi < num_ports_lp; gi++) begin : g_link
        localparam int y_lp = gi / num_in_x_p;
        localparam int x_lp = gi % num_in_x_p;
        logic [link_sif_width_lp-1:0] link_in;

        assign link_in           = links_sif_i[y_lp][x_lp];
        assign fwd_in_v[gi]      = link_in[rev_ch_width_lp + fwd_packet_width_lp + 1];
        assign fwd_in_data[gi]   = link_in[rev_ch_width_lp + 1 +: fwd_packet_width_lp];
        assign fwd_out_ready[gi] = link_in[rev_ch_width_lp];
        assign rev_in_v[gi]      = link_in[rev_packet_width_lp + 1];
        assign rev_in_data[gi]   = link_in[1 +: rev_packet_width_lp];
        assign rev_out_ready[gi] = link_in[0];

        assign links_sif_o[y_lp][x_lp] = {fwd_out_v[gi], fwd_out_data[gi], fwd_in_ready[gi],
                                          rev_out_v[gi], rev_out_data[gi], rev_in_ready[gi]};
    end

    bsg_manycore_crossbar_net #(
        .num_in_x_p(num_in_x_p), .num_in_y_p(num_in_y_p),
        .x_cord_width_p(x_cord_width_p), .y_cord_width_p(y_cord_width_p),
        .width_p(fwd_packet_width_lp), .fifo_els_p(fwd_fifo_els_p),
        .use_credits_p(fwd_use_credits_p), .bad_dest_error_p(bad_dest_error_p)
    ) fwd_net (
        .clk(clk_i), .rst_n(reset_i),
        .in_v(fwd_in_v), .in_data(fwd_in_data), .in_ready(fwd_in_ready),
        .out_v(fwd_out_v), .out_data(fwd_out_data), .out_ready(fwd_out_ready)
    );

    bsg_manycore_crossbar_net #(
        .num_in_x_p(num_in_x_p), .num_in_y_p(num_in_y_p),
        .x_cord_width_p(x_cord_width_p), .y_cord_width_p(y_cord_width_p),
        .width_p(rev_packet_width_lp), .fifo_els_p(rev_fifo_els_p),
        .use_credits_p(rev_use_credits_p), .bad_dest_error_p(bad_dest_error_p)
    ) rev_net (
        .clk(clk_i), .rst_n(reset_i),
        .in_v(rev_in_v), .in_data(rev_in_data), .in_ready(rev_in_ready),
        .out_v(rev_out_v), .out_data(rev_out_data), .out_ready(rev_out_ready)
    );

endmodule

// File: tb/tb_bsg_manycore_crossbar.sv
// Bench for bsg_manycore_crossbar: 3x2 ports, depth 4, fwd port 2 in credit mode.
// A queue-based model predicts every output, ready and credit pulse each cycle.
module tb_bsg_manycore_crossbar;
    localparam int X = 3, Y = 2, N = 6, D = 4;
    localparam int FW = 99, RW = 53;

    typedef struct packed { logic v; logic [FW-1:0] data; logic ready_and_rev; } fwd_ch_t;
    typedef struct packed { logic v; logic [RW-1:0] data; logic ready_and_rev; } rev_ch_t;
    typedef struct packed { fwd_ch_t fwd; rev_ch_t rev; } link_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    link_t [Y-1:0][X-1:0] links_in, links_out;

    always #5 clk = ~clk;

    bsg_manycore_crossbar #(
        .num_in_x_p(X), .num_in_y_p(Y),
        .fwd_fifo_els_p({6{32'd4}}), .rev_fifo_els_p({6{32'd4}}),
        .fwd_use_credits_p(6'b000100), .rev_use_credits_p(6'b000000),
        .bad_dest_error_p(1'b0)
    ) dut (
        .clk_i(clk), .reset_i(reset_n), .links_sif_i(links_in), .links_sif_o(links_out)
    );

    // stimulus state (index 0 = fwd, 1 = rev)
    logic [1:0][N-1:0] in_v, out_rdy, acc, hold;
    logic [FW-1:0]     in_pkt [2][N];

    // reference model
    logic [FW-1:0]     q [2][N][$];
    int                ptr  [2][N];
    int                held [2][N];
    logic [1:0][N-1:0] credit_pend;

    int errors = 0, checks = 0;
    int pulse_cnt = 0;
    int log_n = -1, log_d = 0;
    logic [FW-1:0] log_q [$];

    task automatic check(string tag, logic [FW-1:0] obs, logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_credit(int n, int s);
        return (n == 0) && (s == 2);
    endfunction

    function automatic bit dest_ok(logic [FW-1:0] p);
        return (int'(p[6:0]) < X) && (int'(p[13:7]) < Y);
    endfunction

    function automatic int dest_of(logic [FW-1:0] p);
        return int'(p[13:7]) * X + int'(p[6:0]);
    endfunction

    function automatic logic [FW-1:0] make_pkt(int n, int src, int x, int y, int tag);
        logic [FW-1:0] p;
        p = FW'({$urandom(), $urandom(), $urandom(), $urandom()});
        p[6:0]   = 7'(x);
        p[13:7]  = 7'(y);
        p[17:14] = 4'(src);
        p[21:18] = 4'(tag);
        if (n == 1) p[FW-1:RW] = '0;
        return p;
    endfunction

    function automatic logic dut_out_v(int n, int d);
        return (n == 0) ? links_out[d/X][d%X].fwd.v : links_out[d/X][d%X].rev.v;
    endfunction

    function automatic logic [FW-1:0] dut_out_data(int n, int d);
        return (n == 0) ? links_out[d/X][d%X].fwd.data : FW'(links_out[d/X][d%X].rev.data);
    endfunction

    function automatic logic dut_in_ready(int n, int s);
        return (n == 0) ? links_out[s/X][s%X].fwd.ready_and_rev : links_out[s/X][s%X].rev.ready_and_rev;
    endfunction

    // Round-robin winner for output d: a stalled grant sticks, otherwise scan from the pointer.
    function automatic int pick(int n, int d);
        int s;
        if (held[n][d] >= 0) return held[n][d];
        for (int i = 0; i < N; i++) begin
            s = (ptr[n][d] + i) % N;
            if (q[n][s].size() > 0 && dest_ok(q[n][s][0]) && dest_of(q[n][s][0]) == d) return s;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            links_in[s/X][s%X].fwd.v             = in_v[0][s];
            links_in[s/X][s%X].fwd.data          = in_pkt[0][s];
            links_in[s/X][s%X].fwd.ready_and_rev = out_rdy[0][s];
            links_in[s/X][s%X].rev.v             = in_v[1][s];
            links_in[s/X][s%X].rev.data          = in_pkt[1][s][RW-1:0];
            links_in[s/X][s%X].rev.ready_and_rev = out_rdy[1][s];
        end
    endtask

    task automatic clear_model();
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < N; s++) begin
                q[n][s].delete();
                ptr[n][s]  = 0;
                held[n][s] = -1;
            end
        credit_pend = '0;
        hold = '0;
        acc = '0;
    endtask

    task automatic cycle();
        int win [N];
        int sz [N];
        logic [N-1:0] popped;
        @(negedge clk);
        drive();
        #1;
        for (int n = 0; n < 2; n++) begin
            for (int s = 0; s < N; s++) sz[s] = q[n][s].size();
            for (int d = 0; d < N; d++) begin
                win[d] = pick(n, d);
                check($sformatf("out_v n%0d p%0d", n, d), FW'(dut_out_v(n, d)), FW'(win[d] >= 0));
                if (win[d] >= 0)
                    check($sformatf("out_data n%0d p%0d", n, d), dut_out_data(n, d), q[n][win[d]][0]);
            end
            for (int s = 0; s < N; s++)
                check($sformatf("ready n%0d p%0d", n, s), FW'(dut_in_ready(n, s)),
                      FW'(is_credit(n, s) ? credit_pend[n][s] : (sz[s] < D)));
            if (n == log_n && dut_out_v(n, log_d) && out_rdy[n][log_d])
                log_q.push_back(dut_out_data(n, log_d));
            popped = '0;
            for (int s = 0; s < N; s++)
                if (sz[s] > 0 && !dest_ok(q[n][s][0])) begin
                    void'(q[n][s].pop_front());
                    popped[s] = 1'b1;
                end
            for (int d = 0; d < N; d++) begin
                held[n][d] = -1;
                if (win[d] >= 0) begin
                    if (out_rdy[n][d]) begin
                        void'(q[n][win[d]].pop_front());
                        popped[win[d]] = 1'b1;
                        ptr[n][d] = (win[d] + 1) % N;
                    end else begin
                        held[n][d] = win[d];
                    end
                end
            end
            credit_pend[n] = popped;
            for (int s = 0; s < N; s++) begin
                acc[n][s] = in_v[n][s] && (sz[s] < D);
                if (acc[n][s]) q[n][s].push_back(in_pkt[n][s]);
            end
        end
        pulse_cnt += int'(dut_in_ready(0, 2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        for (int n = 0; n < 2; n++)
            for (int d = 0; d < N; d++)
                check($sformatf("reset out_v n%0d p%0d", n, d), FW'(dut_out_v(n, d)), '0);
        clear_model();
        in_v = '0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [FW-1:0] p028, good031;
        logic [FW-1:0] sent [5];
        int exp_src [6];
        int k;

        in_v = '0;
        out_rdy = '1;
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < N; s++) in_pkt[n][s] = '0;
        clear_model();
        drive();
        do_reset();

        // single fwd packet 0 -> (x=2,y=1) = port 5, visible one cycle later
        p028 = make_pkt(0, 0, 2, 1, 0);
        in_v[0][0] = 1'b1; in_pkt[0][0] = p028;
        cycle();
        in_v = '0;
        cycle();
        check("req028 v", FW'(links_out[1][2].fwd.v), FW'(1'b1));
        check("req028 data", links_out[1][2].fwd.data, p028);
        check("req028 ready", FW'(links_out[0][0].fwd.ready_and_rev), FW'(1'b1));
        repeat (2) cycle();

        // ports 0,1,3 each send two packets to port 4: round-robin order 0,1,3,0,1,3
        log_n = 0; log_d = 4; log_q.delete();
        for (int r = 0; r < 2; r++) begin
            in_v[0][0] = 1'b1; in_pkt[0][0] = make_pkt(0, 0, 1, 1, r);
            in_v[0][1] = 1'b1; in_pkt[0][1] = make_pkt(0, 1, 1, 1, r);
            in_v[0][3] = 1'b1; in_pkt[0][3] = make_pkt(0, 3, 1, 1, r);
            cycle();
        end
        in_v = '0;
        repeat (8) cycle();
        exp_src[0] = 0; exp_src[1] = 1; exp_src[2] = 3;
        exp_src[3] = 0; exp_src[4] = 1; exp_src[5] = 3;
        check("req029 count", FW'(log_q.size()), FW'(6));
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            check($sformatf("req029 src %0d", i), FW'(log_q[i][17:14]), FW'(exp_src[i]));

        // backpressure: port 4 stalled, port 0 fills its FIFO, then drains in order
        log_q.delete();
        out_rdy[0][4] = 1'b0;
        for (int i = 0; i < 5; i++) sent[i] = make_pkt(0, 0, 1, 1, i);
        k = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 6) out_rdy[0][4] = 1'b1;
            in_v[0][0] = (k < 5);
            if (k < 5) in_pkt[0][0] = sent[k];
            cycle();
            if (c == 4) check("req030 full ready", FW'(links_out[0][0].fwd.ready_and_rev), '0);
            if (acc[0][0]) k++;
        end
        in_v = '0;
        check("req030 count", FW'(log_q.size()), FW'(5));
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            check($sformatf("req030 pkt %0d", i), log_q[i], sent[i]);

        // rev packet to x=7 is dropped; the next packet from the same port still flows
        log_n = 1; log_d = 3; log_q.delete();
        good031 = make_pkt(1, 1, 0, 1, 5);
        in_v[1][1] = 1'b1; in_pkt[1][1] = make_pkt(1, 1, 7, 0, 4);
        cycle();
        in_pkt[1][1] = good031;
        cycle();
        in_v = '0;
        repeat (4) cycle();
        check("req031 count", FW'(log_q.size()), FW'(1));
        if (log_q.size() > 0) check("req031 pkt", log_q[0], good031);
        log_n = -1;

        // credit port 2 sends three packets: exactly three credit pulses
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            in_v[0][2] = 1'b1; in_pkt[0][2] = make_pkt(0, 2, 0, 0, i);
            cycle();
        end
        in_v = '0;
        repeat (6) cycle();
        check("req032 pulses", FW'(pulse_cnt), FW'(3));

        // reset with packets queued behind a stalled output
        out_rdy[0] = '0;
        in_v[0][0] = 1'b1; in_pkt[0][0] = make_pkt(0, 0, 0, 1, 1);
        in_v[0][1] = 1'b1; in_pkt[0][1] = make_pkt(0, 1, 0, 1, 2);
        in_v[0][5] = 1'b1; in_pkt[0][5] = make_pkt(0, 5, 0, 1, 3);
        cycle();
        in_v = '0;
        cycle();
        do_reset();
        out_rdy = '1;
        repeat (5) cycle();

        // randomized traffic with random backpressure and occasional bad destinations
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                for (int s = 0; s < N; s++) begin
                    out_rdy[n][s] = ($urandom_range(0, 3) != 0);
                    if (is_credit(n, s)) begin
                        in_v[n][s] = (q[n][s].size() < D) && ($urandom_range(0, 1) == 1);
                        if (in_v[n][s])
                            in_pkt[n][s] = make_pkt(n, s, $urandom_range(0, X-1), $urandom_range(0, Y-1), c);
                    end else if (!hold[n][s]) begin
                        in_v[n][s] = ($urandom_range(0, 1) == 1);
                        if (in_v[n][s])
                            in_pkt[n][s] = make_pkt(n, s,
                                ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, X-1),
                                $urandom_range(0, Y-1), c);
                    end
                end
            end
            cycle();
            hold = in_v & ~acc;
        end
        in_v = '0;
        out_rdy = '1;
        repeat (12) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bsg_manycore_crossbar.md
BSG_MANYCORE_CROSSBAR -- requirements
Module: bsg_manycore_crossbar

Interface
REQ-001 Parameter num_in_x_p, default 17: ports per row.
REQ-002 Parameter num_in_y_p, default 8: rows; N = num_in_x_p*num_in_y_p ports; port index p = y*num_in_x_p + x.
REQ-003 Parameters addr_width_p (28), data_width_p (32), x_cord_width_p (7), y_cord_width_p (7): the standard manycore packet and link widths.
REQ-004 Parameters fwd_fifo_els_p[N] and rev_fifo_els_p[N], default 32 each: input FIFO depth for each port.
REQ-005 Parameters fwd_use_credits_p[N] and rev_use_credits_p[N], default 0: credit-mode flag for each port.
REQ-006 clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 reset_i  input  1  reset; asynchronous and active-low.
REQ-008 links_sif_i  input  [num_in_y_p][num_in_x_p] link_sif: per-port fwd and rev channels, each carrying v, packet and ready_and_rev.
REQ-009 links_sif_o  output  [num_in_y_p][num_in_x_p] link_sif: same structure as links_sif_i.

Function
REQ-010 Fwd and rev networks are independent, identical N-by-N crossbars; the rules below apply to each.
REQ-011 Input side: each port has a FIFO of the configured depth; a packet is enqueued when links_sif_i[p].v=1 and the FIFO has space.
REQ-012 Non-credit port: links_sif_o[p].ready_and_rev = FIFO not full; a valid presented while the FIFO is full is not accepted and must be held by the sender.
REQ-013 Credit port: links_sif_o[p].ready_and_rev is a one-cycle credit pulse per FIFO dequeue; the sender owns the count; overflow in credit mode is an error (assertion).
REQ-014 Destination decode: x_cord is the LSB field [x_cord_width_p-1:0] of both packet types; y_cord is the next y_cord_width_p bits; destination port = y_cord*num_in_x_p + x_cord.
REQ-015 A FIFO head with x_cord >= num_in_x_p or y_cord >= num_in_y_p is dequeued and dropped in one cycle, never forwarded, and flagged by a simulation $error.
REQ-016 Each output port has a round-robin arbiter over all N FIFO heads targeting it; at most one grant per output per cycle.
REQ-017 Heads targeting different outputs proceed in parallel in the same cycle.
REQ-018 Output side: links_sif_o[d].v = 1 when a grant exists; the packet is the granted head, passed combinationally from FIFO head to output.
REQ-019 The grant is consumed and the head dequeued only when links_sif_i[d].ready_and_rev = 1 in that cycle.
REQ-020 Round-robin pointer advances to one past the winner only on a consumed transfer; a stalled output keeps the same grant (no valid withdrawal).
REQ-021 Latency: a packet enqueued in cycle t is visible at an idle, ready output in cycle t+1; throughput is 1 packet per output per cycle.
REQ-022 Packet order between any single input/output pair is preserved.
REQ-023 Simultaneous enqueue and dequeue on a full FIFO does not free the input, because ready_and_rev is registered/full-based; on an empty FIFO the packet is not bypassed (REQ-021 latency applies).
REQ-024 A port sending to itself is legal.

Reset
REQ-025 While reset_i = 0: all FIFOs empty, every links_sif_o v = 0, all arbiter pointers = port 0, no credit pulses.
REQ-026 Non-credit ready_and_rev goes high in the first cycle after reset deasserts.
REQ-027 Reset asserted mid-transfer discards all queued packets immediately and asynchronously.

Verification (num_in_x_p=3, num_in_y_p=2, depth 4)
REQ-028 Fwd packet x=2, y=1 injected at port 0 at cycle t -> port 5 fwd v=1 with an identical packet at t+1; port 0 ready stays 1.
REQ-029 Ports 0, 1 and 3 each send 2 packets to port 4 with ready held 1 -> 6 packets out on consecutive cycles in order 0,1,3,0,1,3.
REQ-030 Port 4 ready=0, port 0 sends 5 packets to port 4 -> port 0 ready=0 after 4 accepted; all 5 delivered in order once ready=1.
REQ-031 Rev packet x=7, y=0 injected -> dropped, $error raised, no output v anywhere, subsequent packets unaffected.
REQ-032 Credit port 2 sends 3 packets -> exactly 3 one-cycle ready pulses as the packets leave the FIFO.
REQ-033 Reset pulled low with 3 packets queued -> all v=0 at once; after release, no stale packets appear.
